// File: rtl/alu_seq_exec.sv
// ALU control decode plus execute stage for EX.
// Decodes ALUOp/funct3/funct7/funct7_m into a 4-bit operation and executes it on
// XLEN-bit operands behind a valid/ready handshake. Single-cycle ops return one
// cycle after accept; MUL runs an iterative shift-add for XLEN cycles.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | ready for a request; single-cycle results issue from here
// MUL    | shift-add iterations, one operand bit per cycle, XLEN cycles
// DONE   | MUL result on o_valid this cycle; returns to IDLE next cycle

module alu_seq_exec #(
   parameter int XLEN     = 64,
   parameter int OP_WIDTH = 2,
   parameter bit MUL_EN   = 1'b1
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_valid,
   output logic                o_ready,
   input  logic [OP_WIDTH-1:0] i_ALUOp,
   input  logic [2:0]          i_funct_3,
   input  logic                i_funct7,
   input  logic                i_funct7_m,
   input  logic [XLEN-1:0]     i_op_a,
   input  logic [XLEN-1:0]     i_op_b,
   output logic                o_valid,
   output logic [XLEN-1:0]     o_result,
   output logic                o_zero,
   output logic                o_illegal,
   output logic [3:0]          o_ALU_Operation
);

   localparam int SHAMT_W = $clog2(XLEN);
   localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(XLEN - 1);

   localparam logic [3:0] OP_ILL  = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_AND  = 4'b0011;
   localparam logic [3:0] OP_OR   = 4'b0100;
   localparam logic [3:0] OP_XOR  = 4'b0101;
   localparam logic [3:0] OP_SLL  = 4'b0110;
   localparam logic [3:0] OP_SRL  = 4'b0111;
   localparam logic [3:0] OP_SRA  = 4'b1000;
   localparam logic [3:0] OP_SLT  = 4'b1001;
   localparam logic [3:0] OP_SLTU = 4'b1010;
   localparam logic [3:0] OP_MUL  = 4'b1011;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state;
   logic [3:0]          dec_op;
   logic [XLEN-1:0]     alu_res;
   logic [SHAMT_W-1:0]  shamt;
   logic [XLEN-1:0]     mul_a;
   logic [XLEN-1:0]     mul_b;
   logic [XLEN-1:0]     mul_acc;
   logic [XLEN-1:0]     mul_acc_next;
   logic [SHAMT_W-1:0]  mul_cnt;
   logic                is_rtype;

   assign shamt        = i_op_b[SHAMT_W-1:0];
   assign is_rtype     = (i_ALUOp == 2'b10);
   assign mul_acc_next = mul_b[0] ? (mul_acc + mul_a) : mul_acc;

   // Decode the control fields into the 4-bit operation code.
   always_comb begin
      dec_op = OP_ILL;
      case (i_ALUOp)
         2'b00: dec_op = OP_ADD;
         2'b01: dec_op = OP_SUB;
         default: begin
            // funct7_m only selects the M extension on R-type; I-type ignores it.
            if (is_rtype && i_funct7_m) begin
               dec_op = (i_funct_3 == 3'b000 && MUL_EN) ? OP_MUL : OP_ILL;
            end else begin
               case (i_funct_3)
                  3'b000:  dec_op = (is_rtype && i_funct7) ? OP_SUB : OP_ADD;
                  3'b001:  dec_op = OP_SLL;
                  3'b010:  dec_op = OP_SLT;
                  3'b011:  dec_op = OP_SLTU;
                  3'b100:  dec_op = OP_XOR;
                  3'b101:  dec_op = i_funct7 ? OP_SRA : OP_SRL;
                  3'b110:  dec_op = OP_OR;
                  default: dec_op = OP_AND;
               endcase
            end
         end
      endcase
   end

   // Single-cycle datapath; illegal and MUL produce zero here.
   always_comb begin
      alu_res = '0;
      case (dec_op)
         OP_ADD:  alu_res = i_op_a + i_op_b;
         OP_SUB:  alu_res = i_op_a - i_op_b;
         OP_AND:  alu_res = i_op_a & i_op_b;
         OP_OR:   alu_res = i_op_a | i_op_b;
         OP_XOR:  alu_res = i_op_a ^ i_op_b;
         OP_SLL:  alu_res = i_op_a << shamt;
         OP_SRL:  alu_res = i_op_a >> shamt;
         OP_SRA:  alu_res = $unsigned($signed(i_op_a) >>> shamt);
         OP_SLT:  alu_res = XLEN'($signed(i_op_a) < $signed(i_op_b));
         OP_SLTU: alu_res = XLEN'(i_op_a < i_op_b);
         default: alu_res = '0;
      endcase
   end

   // Sequencer: handshake, result registers and the iterative multiplier.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state           <= S_IDLE;
         o_ready         <= 1'b1;
         o_valid         <= 1'b0;
         o_result        <= '0;
         o_zero          <= 1'b1;
         o_illegal       <= 1'b0;
         o_ALU_Operation <= OP_ILL;
         mul_a           <= '0;
         mul_b           <= '0;
         mul_acc         <= '0;
         mul_cnt         <= '0;
      end else begin
         o_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_valid && o_ready) begin
                  o_ALU_Operation <= dec_op;
                  if (dec_op == OP_MUL) begin
                     mul_a   <= i_op_a;
                     mul_b   <= i_op_b;
                     mul_acc <= '0;
                     mul_cnt <= '0;
                     o_ready <= 1'b0;
                     state   <= S_MUL;
                  end else begin
                     o_valid   <= 1'b1;
                     o_result  <= alu_res;
                     o_zero    <= (alu_res == '0);
                     o_illegal <= (dec_op == OP_ILL);
                  end
               end
            end
            S_MUL: begin
               mul_acc <= mul_acc_next;
               mul_a   <= mul_a << 1;
               mul_b   <= mul_b >> 1;
               mul_cnt <= mul_cnt + SHAMT_W'(1);
               // Final iteration: publish directly so the result is valid during DONE.
               if (mul_cnt == CNT_LAST) begin
                  o_valid   <= 1'b1;
                  o_result  <= mul_acc_next;
                  o_zero    <= (mul_acc_next == '0);
                  o_illegal <= 1'b0;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               o_ready <= 1'b1;
               state   <= S_IDLE;
            end
            default: begin
               o_ready <= 1'b1;
               state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed bench for alu_seq_exec with hand-computed expectations.

module tb_alu_seq_exec;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic        o_ready;
   logic [1:0]  i_ALUOp;
   logic [2:0]  i_funct_3;
   logic        i_funct7;
   logic        i_funct7_m;
   logic [63:0] i_op_a;
   logic [63:0] i_op_b;
   logic        o_valid;
   logic [63:0] o_result;
   logic        o_zero;
   logic        o_illegal;
   logic [3:0]  o_ALU_Operation;

   int checks = 0;
   int errors = 0;

   alu_seq_exec #(.XLEN(64), .OP_WIDTH(2), .MUL_EN(1'b1)) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_valid         (i_valid),
      .o_ready         (o_ready),
      .i_ALUOp         (i_ALUOp),
      .i_funct_3       (i_funct_3),
      .i_funct7        (i_funct7),
      .i_funct7_m      (i_funct7_m),
      .i_op_a          (i_op_a),
      .i_op_b          (i_op_b),
      .o_valid         (o_valid),
      .o_result        (o_result),
      .o_zero          (o_zero),
      .o_illegal       (o_illegal),
      .o_ALU_Operation (o_ALU_Operation)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [1:0]  aluop;
      logic [2:0]  f3;
      logic        f7;
      logic        f7m;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
      logic [3:0]  op;
   } vec_t;

   task automatic drive(input logic [1:0] aluop, input logic [2:0] f3, input logic f7,
                        input logic f7m, input logic [63:0] a, input logic [63:0] b);
      i_ALUOp    = aluop;
      i_funct_3  = f3;
      i_funct7   = f7;
      i_funct7_m = f7m;
      i_op_a     = a;
      i_op_b     = b;
      i_valid    = 1'b1;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      i_valid = 1'b0;
      drive(2'b00, 3'b000, 1'b0, 1'b0, 64'd0, 64'd0);
      i_valid = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
      checks++; if (o_result !== 64'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", o_result); end
      checks++; if (o_zero !== 1'b1) begin errors++; $display("FAIL reset_zero got=%b exp=1", o_zero); end
      checks++; if (o_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", o_illegal); end
      checks++; if (o_ALU_Operation !== 4'b0000) begin errors++; $display("FAIL reset_op got=%b exp=0000", o_ALU_Operation); end
   endtask

   task automatic test_sub();
      drive(2'b10, 3'b000, 1'b1, 1'b0, 64'd5, 64'd7);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL sub_valid got=%b exp=1", o_valid); end
      checks++; if (o_result !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL sub_result got=%h exp=fffffffffffffffe", o_result); end
      checks++; if (o_zero !== 1'b0) begin errors++; $display("FAIL sub_zero got=%b exp=0", o_zero); end
      checks++; if (o_ALU_Operation !== 4'b0010) begin errors++; $display("FAIL sub_op got=%b exp=0010", o_ALU_Operation); end
      @(posedge i_clk); #1;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL sub_pulse got=%b exp=0", o_valid); end
      checks++; if (o_result !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL sub_hold got=%h exp=fffffffffffffffe", o_result); end
   endtask

   task automatic test_beq();
      drive(2'b01, 3'b000, 1'b0, 1'b0, 64'h1234, 64'h1234);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      checks++; if (o_zero !== 1'b1) begin errors++; $display("FAIL beq_zero got=%b exp=1", o_zero); end
      checks++; if (o_result !== 64'd0) begin errors++; $display("FAIL beq_result got=%h exp=0", o_result); end
      checks++; if (o_ALU_Operation !== 4'b0010) begin errors++; $display("FAIL beq_op got=%b exp=0010", o_ALU_Operation); end
   endtask

   task automatic test_sra();
      drive(2'b10, 3'b101, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd4);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      checks++; if (o_result !== 64'hF800_0000_0000_0000) begin errors++; $display("FAIL sra_result got=%h exp=f800000000000000", o_result); end
      checks++; if (o_ALU_Operation !== 4'b1000) begin errors++; $display("FAIL sra_op got=%b exp=1000", o_ALU_Operation); end
   endtask

   task automatic test_itype_add();
      drive(2'b11, 3'b000, 1'b1, 1'b0, 64'd5, 64'd7);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      checks++; if (o_result !== 64'd12) begin errors++; $display("FAIL iadd_result got=%h exp=c", o_result); end
      checks++; if (o_ALU_Operation !== 4'b0001) begin errors++; $display("FAIL iadd_op got=%b exp=0001", o_ALU_Operation); end
   endtask

   task automatic test_illegal();
      drive(2'b10, 3'b100, 1'b0, 1'b1, 64'd5, 64'd7);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL ill_valid got=%b exp=1", o_valid); end
      checks++; if (o_illegal !== 1'b1) begin errors++; $display("FAIL ill_flag got=%b exp=1", o_illegal); end
      checks++; if (o_result !== 64'd0) begin errors++; $display("FAIL ill_result got=%h exp=0", o_result); end
      checks++; if (o_zero !== 1'b1) begin errors++; $display("FAIL ill_zero got=%b exp=1", o_zero); end
      checks++; if (o_ALU_Operation !== 4'b0000) begin errors++; $display("FAIL ill_op got=%b exp=0000", o_ALU_Operation); end
   endtask

   task automatic test_ops();
      vec_t v [10];
      v[0] = '{2'b10, 3'b001, 1'b0, 1'b0, 64'd1, 64'd65, 64'd2, 4'b0110};
      v[1] = '{2'b10, 3'b010, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 4'b1001};
      v[2] = '{2'b10, 3'b011, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b1010};
      v[3] = '{2'b10, 3'b101, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 4'b0111};
      v[4] = '{2'b10, 3'b110, 1'b0, 1'b0, 64'hF0, 64'h0F, 64'hFF, 4'b0100};
      v[5] = '{2'b10, 3'b111, 1'b0, 1'b0, 64'hF0, 64'h3C, 64'h30, 4'b0011};
      v[6] = '{2'b11, 3'b101, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC, 4'b1000};
      v[7] = '{2'b00, 3'b000, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0001};
      v[8] = '{2'b11, 3'b000, 1'b1, 1'b1, 64'd5, 64'd7, 64'd12, 4'b0001};
      v[9] = '{2'b10, 3'b000, 1'b0, 1'b0, 64'd5, 64'd7, 64'd12, 4'b0001};
      for (int i = 0; i < 10; i++) begin
         drive(v[i].aluop, v[i].f3, v[i].f7, v[i].f7m, v[i].a, v[i].b);
         @(posedge i_clk); #1;
         checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL ops%0d_valid got=%b exp=1", i, o_valid); end
         checks++; if (o_result !== v[i].res) begin errors++; $display("FAIL ops%0d_result got=%h exp=%h", i, o_result, v[i].res); end
         checks++; if (o_zero !== (v[i].res == 64'd0)) begin errors++; $display("FAIL ops%0d_zero got=%b exp=%b", i, o_zero, (v[i].res == 64'd0)); end
         checks++; if (o_illegal !== 1'b0) begin errors++; $display("FAIL ops%0d_illegal got=%b exp=0", i, o_illegal); end
         checks++; if (o_ALU_Operation !== v[i].op) begin errors++; $display("FAIL ops%0d_op got=%b exp=%b", i, o_ALU_Operation, v[i].op); end
      end
      i_valid = 1'b0;
      @(posedge i_clk); #1;
   endtask

   task automatic test_mul();
      int  cyc;
      bit  got;
      bit  ready_bad;
      drive(2'b10, 3'b000, 1'b0, 1'b1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      checks++; if (o_ready !== 1'b0 || o_valid !== 1'b0) begin errors++; $display("FAIL mul_start got ready=%b valid=%b exp ready=0 valid=0", o_ready, o_valid); end
      checks++; if (o_ALU_Operation !== 4'b1011) begin errors++; $display("FAIL mul_op got=%b exp=1011", o_ALU_Operation); end
      cyc = 0;
      got = 1'b0;
      ready_bad = 1'b0;
      while (!got && cyc < 100) begin
         if (cyc == 10 || cyc == 40) drive(2'b00, 3'b000, 1'b0, 1'b0, 64'd1, 64'd1);
         else i_valid = 1'b0;
         @(posedge i_clk); #1;
         cyc++;
         if (o_ready !== 1'b0) ready_bad = 1'b1;
         if (o_valid === 1'b1) got = 1'b1;
      end
      i_valid = 1'b0;
      checks++; if (!got) begin errors++; $display("FAIL mul_timeout got=no o_valid exp=o_valid within 100 cycles"); end
      checks++; if (cyc != 64) begin errors++; $display("FAIL mul_latency got=%0d exp=64 edges after accept", cyc); end
      checks++; if (o_result !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL mul_result got=%h exp=fffffffffffffffd", o_result); end
      checks++; if (o_zero !== 1'b0 || o_illegal !== 1'b0) begin errors++; $display("FAIL mul_flags got zero=%b illegal=%b exp 0 0", o_zero, o_illegal); end
      checks++; if (ready_bad) begin errors++; $display("FAIL mul_ready_low got=ready high while busy exp=low"); end
      checks++; if (o_ALU_Operation !== 4'b1011) begin errors++; $display("FAIL mul_op_held got=%b exp=1011", o_ALU_Operation); end
      @(posedge i_clk); #1;
      checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL mul_after got ready=%b valid=%b exp ready=1 valid=0", o_ready, o_valid); end
   endtask

   task automatic test_mul_reset();
      int nvalid;
      drive(2'b10, 3'b000, 1'b0, 1'b1, 64'd7, 64'd9);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      repeat (29) @(posedge i_clk);
      #1;
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL mulrst_state got ready=%b valid=%b exp ready=1 valid=0", o_ready, o_valid); end
      checks++; if (o_result !== 64'd0 || o_ALU_Operation !== 4'b0000) begin errors++; $display("FAIL mulrst_clear got result=%h op=%b exp 0 0000", o_result, o_ALU_Operation); end
      nvalid = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge i_clk); #1;
         if (o_valid === 1'b1) nvalid++;
      end
      checks++; if (nvalid != 0) begin errors++; $display("FAIL mulrst_novalid got=%0d pulses exp=0", nvalid); end
   endtask

   task automatic test_back_to_back();
      drive(2'b10, 3'b000, 1'b0, 1'b0, 64'd10, 64'd20);
      @(posedge i_clk); #1;
      checks++; if (o_valid !== 1'b1 || o_result !== 64'd30) begin errors++; $display("FAIL b2b_add got valid=%b result=%h exp 1 1e", o_valid, o_result); end
      drive(2'b10, 3'b100, 1'b0, 1'b0, 64'hF0, 64'hFF);
      @(posedge i_clk); #1;
      checks++; if (o_valid !== 1'b1 || o_result !== 64'h0F) begin errors++; $display("FAIL b2b_xor got valid=%b result=%h exp 1 f", o_valid, o_result); end
      drive(2'b10, 3'b011, 1'b0, 1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      checks++; if (o_valid !== 1'b1 || o_result !== 64'd1) begin errors++; $display("FAIL b2b_sltu got valid=%b result=%h exp 1 1", o_valid, o_result); end
      checks++; if (o_ALU_Operation !== 4'b1010) begin errors++; $display("FAIL b2b_op got=%b exp=1010", o_ALU_Operation); end
      @(posedge i_clk); #1;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got=%b exp=0", o_valid); end
   endtask

   initial begin
      test_reset();
      test_sub();
      test_beq();
      test_sra();
      test_itype_add();
      test_illegal();
      test_ops();
      test_mul();
      test_mul_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=time limit reached exp=bench completion");
      $fatal(1, "watchdog expired");
   end

endmodule
